// File: rtl/vga_fb_pkg.sv
// Shared defaults and the grant encoding for the framebuffer arbiter.
//   DEF_DATA_W   : default pixel / memory word width
//   DEF_ADDR_W   : default memory address width
//   DEF_FB_WORDS : default framebuffer length in words
//   gnt_e        : memory-cycle grant (none, scanout read, MCU write)
package vga_fb_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 14;
    localparam int unsigned DEF_FB_WORDS = 16384;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// MCU write channel plus single-port RAM channel of the framebuffer arbiter.
//   wr_valid/wr_ready/wr_addr/wr_data : MCU write request and acceptance
//   mem_en/mem_we/mem_addr/mem_wdata  : RAM access for this cycle
//   mem_rdata                         : RAM read data, one cycle after a read
// slave  : arbiter side (consumes writes, drives the RAM)
// master : environment side (FSMC bridge and RAM)
interface vga_fb_arbiter_if
    import vga_fb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_prefetch_fifo.sv
// Synchronous pixel prefetch FIFO with flush.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write push_data this edge (ignored when full without a pop)
//   push_data  : word to enqueue
//   pop        : drop the head word this edge (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop
//   count      : current occupancy, 0..FIFO_DEPTH
//   head       : word at the head (stale when empty)
module fb_prefetch_fifo #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  logic [DATA_W-1:0]                   push_data,
    input  logic                                pop,
    input  logic                                flush,
    output logic [$clog2(FIFO_DEPTH):0]         count,
    output logic [DATA_W-1:0]                   head
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // Pointer/occupancy update; power-of-2 depth lets pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != DEPTH_CNT) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // The arbiter's inflight accounting must never push into a full FIFO.
            if (push && !flush && !do_pop) begin
                assert (count_q != DEPTH_CNT);
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scanout prefetch and
// MCU writes, keeping the pixel prefetch FIFO topped up.
//   clk, rst_n  : clock, synchronous active-low reset
//   frame_start : flush FIFO, restart fetch at 0, clear underrun
//   pix_req     : pop one pixel; pix_data valid the next cycle
//   pix_data    : registered pixel (0 on an empty pop or frame start)
//   underrun    : sticky, set by a pop on an empty FIFO
//   bus         : MCU write channel and RAM channel (slave side)
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned FB_WORDS   = DEF_FB_WORDS,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LOW_WM     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 pix_req,
    output logic [DATA_W-1:0]    pix_data,
    output logic                 underrun,
    vga_fb_arbiter_if.slave      bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    logic [CNT_W-1:0]  occ;
    logic [DATA_W-1:0] head;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    logic              rd_cand;
    logic              wr_cand;
    logic              below_wm;
    gnt_e              gnt;

    logic [ADDR_W-1:0] fetch_q, fetch_d;
    logic              inflight_q, inflight_d;
    logic              last_wr_q, last_wr_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              underrun_q, underrun_d;

    fb_prefetch_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (bus.mem_rdata),
        .pop       (fifo_pop),
        .flush     (frame_start),
        .count     (occ),
        .head      (head)
    );

    assign fifo_empty = (occ == '0);
    // A read returning during frame_start belongs to the old frame: drop it.
    assign fifo_push  = inflight_q && !frame_start;
    assign fifo_pop   = pix_req && !frame_start;

    // Grant: counting the in-flight read reserves its FIFO slot up front.
    always_comb begin
        rd_cand  = (SUM_W'(occ) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
        wr_cand  = bus.wr_valid;
        below_wm = occ < CNT_W'(LOW_WM);
        gnt      = GNT_NONE;
        if (rst_n && !frame_start) begin
            if (rd_cand && wr_cand) begin
                gnt = (below_wm || last_wr_q) ? GNT_RD : GNT_WR;
            end else if (rd_cand) begin
                gnt = GNT_RD;
            end else if (wr_cand) begin
                gnt = GNT_WR;
            end
        end
    end

    // RAM channel; address/data are don't-care while mem_en is low.
    assign bus.mem_en    = (gnt != GNT_NONE);
    assign bus.mem_we    = (gnt == GNT_WR);
    assign bus.wr_ready  = (gnt == GNT_WR);
    assign bus.mem_addr  = (gnt == GNT_WR) ? bus.wr_addr : fetch_q;
    assign bus.mem_wdata = bus.wr_data;

    // Next-state for fetch counter, inflight flag, round-robin and pixel path.
    always_comb begin
        fetch_d    = fetch_q;
        inflight_d = (gnt == GNT_RD);
        last_wr_d  = last_wr_q;
        pix_data_d = pix_data_q;
        underrun_d = underrun_q;

        if (gnt == GNT_RD) begin
            last_wr_d = 1'b0;
        end else if (gnt == GNT_WR) begin
            last_wr_d = 1'b1;
        end

        if (frame_start) begin
            fetch_d    = '0;
            pix_data_d = '0;
            underrun_d = 1'b0;
        end else begin
            if (gnt == GNT_RD) begin
                fetch_d = (fetch_q == LAST_ADDR) ? '0 : fetch_q + ADDR_W'(1);
            end
            if (pix_req) begin
                pix_data_d = fifo_empty ? '0 : head;
                underrun_d = underrun_q || fifo_empty;
            end
        end
    end

    // last_wr resets high so the first contested cycle goes to the read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_q    <= '0;
            inflight_q <= 1'b0;
            last_wr_q  <= 1'b1;
            pix_data_q <= '0;
            underrun_q <= 1'b0;
        end else begin
            fetch_q    <= fetch_d;
            inflight_q <= inflight_d;
            last_wr_q  <= last_wr_d;
            pix_data_q <= pix_data_d;
            underrun_q <= underrun_d;
        end
    end

    assign pix_data = pix_data_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vga_fb_arbiter;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned FB_WORDS = 16;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned LOW_WM   = 4;

    logic              clk;
    logic              rst_n;
    logic              frame_start;
    logic              pix_req;
    logic [DATA_W-1:0] pix_data;
    logic              underrun;

    int checks;
    int errors;

    logic [DATA_W-1:0] ram [1 << ADDR_W];

    vga_fb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vga_fb_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FB_WORDS   (FB_WORDS),
        .FIFO_DEPTH (DEPTH),
        .LOW_WM     (LOW_WM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .pix_data    (pix_data),
        .underrun    (underrun),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model, preloaded with address-as-data while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= DATA_W'(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        frame_start     = 1'b0;
        pix_req         = 1'b0;
        bus.wr_valid    = 1'b1;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.mem_rdata   = '0;

        // Reset state, with a write request pending
        repeat (3) tick();
        #2;
        chk("rst_pix_data", 32'(pix_data), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_mem_en",   32'(bus.mem_en), 0);
        chk("rst_mem_we",   32'(bus.mem_we), 0);

        // Prefetch reads 0..7 on consecutive cycles, then idle with FIFO full
        tick();
        rst_n        = 1'b1;
        bus.wr_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #2;
            chk("pf_mem_en",   32'(bus.mem_en), 1);
            chk("pf_mem_we",   32'(bus.mem_we), 0);
            chk("pf_mem_addr", 32'(bus.mem_addr), 32'(k));
            tick();
        end
        #2;
        chk("full_idle0", 32'(bus.mem_en), 0);
        tick();
        #2;
        chk("full_idle1", 32'(bus.mem_en), 0);
        chk("idle_underrun", 32'(underrun), 0);

        // Single write with FIFO full
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 14'h0123;
        bus.wr_data  = 16'hBEEF;
        #2;
        chk("wr_ready",  32'(bus.wr_ready), 1);
        chk("wr_mem_en", 32'(bus.mem_en), 1);
        chk("wr_mem_we", 32'(bus.mem_we), 1);
        chk("wr_addr",   32'(bus.mem_addr), 32'h0123);
        chk("wr_wdata",  32'(bus.mem_wdata), 32'hBEEF);
        tick();
        bus.wr_valid = 1'b0;
        #2;
        chk("wr_done_ready", 32'(bus.wr_ready), 0);
        chk("wr_done_en",    32'(bus.mem_en), 0);
        chk("ram_0123",      32'(ram[14'h0123]), 32'hBEEF);

        // Continuous pops plus continuous writes: alternate above the
        // watermark, then reads every cycle; pixel stream wraps 15 -> 0.
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 14'h0200;
        bus.wr_data  = 16'hCAFE;
        pix_req      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #2;
            chk("bw_wr_ready", 32'(bus.wr_ready), (i < 8 && (i % 2) == 0) ? 1 : 0);
            chk("bw_mem_en",   32'(bus.mem_en), 1);
            if (i < 8 && (i % 2) == 0)
                chk("bw_wr_addr", 32'(bus.mem_addr), 32'h0200);
            else if (i < 8)
                chk("bw_rd_addr", 32'(bus.mem_addr), 32'(8 + (i - 1) / 2));
            else
                chk("bw_rd_addr", 32'(bus.mem_addr), 32'((i + 4) % 16));
            if (i > 0) chk("bw_pix_data", 32'(pix_data), 32'((i - 1) % 16));
            chk("bw_underrun", 32'(underrun), 0);
            tick();
        end
        chk("ram_0200", 32'(ram[14'h0200]), 32'hCAFE);

        // frame_start beats pix_req and blocks all grants
        frame_start = 1'b1;
        #2;
        chk("fs_mem_en",   32'(bus.mem_en), 0);
        chk("fs_wr_ready", 32'(bus.wr_ready), 0);
        tick();
        frame_start  = 1'b0;
        bus.wr_valid = 1'b0;
        #2;
        chk("fs_pix_zero",  32'(pix_data), 0);
        chk("fs_no_urun",   32'(underrun), 0);
        chk("fs_rd0",       32'(bus.mem_addr), 0);
        chk("fs_rd0_en",    32'(bus.mem_en), 1);

        // Pop on the flushed FIFO: underrun sets and sticks
        tick();
        pix_req = 1'b0;
        #2;
        chk("ur_set",      32'(underrun), 1);
        chk("ur_pix_zero", 32'(pix_data), 0);
        chk("ur_rd1",      32'(bus.mem_addr), 1);
        for (int j = 2; j < 6; j++) begin
            tick();
            #2;
            chk("ur_rd_addr", 32'(bus.mem_addr), 32'(j));
            chk("ur_sticky",  32'(underrun), 1);
        end

        // frame_start right after the read of address 5: word is discarded
        tick();
        frame_start = 1'b1;
        #2;
        chk("fs2_mem_en",  32'(bus.mem_en), 0);
        chk("fs2_sticky",  32'(underrun), 1);
        tick();
        frame_start = 1'b0;
        #2;
        chk("fs2_urun_clr", 32'(underrun), 0);
        chk("fs2_rd0",      32'(bus.mem_addr), 0);
        tick();
        #2;
        chk("fs2_rd1", 32'(bus.mem_addr), 1);
        tick();
        pix_req = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick();
            #2;
            chk("fs2_pix", 32'(pix_data), 32'(p));
            chk("fs2_urun", 32'(underrun), 0);
        end
        pix_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
